// File: rtl/match_seq_ctrl_if.sv
// rtl/match_seq_ctrl_if.sv - handshake bundle between match sequencer and datapath
interface match_seq_ctrl_if #(
    parameter int STATE_W = 3,
    parameter int CYC_W   = 7
) ();
    logic               en;
    logic               isstring;
    logic               ispattern;
    logic [STATE_W-1:0] dp_flags;
    logic [STATE_W-1:0] state;
    logic               cnt_rst;
    logic               busy;
    logic               timeout;
    logic [CYC_W-1:0]   proc_cycles;
    logic [7:0]         pat_cnt;

    // Master drives the datapath-side inputs and observes the sequencer outputs.
    modport master (
        output en, isstring, ispattern, dp_flags,
        input  state, cnt_rst, busy, timeout, proc_cycles, pat_cnt
    );

    // Slave is the sequencer itself.
    modport slave (
        input  en, isstring, ispattern, dp_flags,
        output state, cnt_rst, busy, timeout, proc_cycles, pat_cnt
    );
endinterface

// File: rtl/match_seq_ctrl.sv
// rtl/match_seq_ctrl.sv - one-hot READ/PROC/OUT sequencer with PROC watchdog
module match_seq_ctrl #(
    parameter int STATE_W  = 3,
    parameter int MAX_PROC = 64,
    parameter int CYC_W    = 7
) (
    input  logic              clk,
    input  logic              reset,
    match_seq_ctrl_if.slave   ctrl
);
    localparam int S_READ = 0;
    localparam int S_PROC = 1;
    localparam int S_OUT  = 2;

    // One-hot encoding; IDLE is all-zero so the state output needs no decode.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = '0,
        ST_READ = STATE_W'(1 << S_READ),
        ST_PROC = STATE_W'(1 << S_PROC),
        ST_OUT  = STATE_W'(1 << S_OUT)
    } state_t;

    state_t           state_q;
    logic             seen_data_q;
    logic [CYC_W-1:0] wd_q;
    logic             timeout_q;
    logic [CYC_W-1:0] proc_cycles_q;
    logic [7:0]       pat_cnt_q;
    logic [7:0]       pat_cnt_d;
    logic             data_valid;
    logic             unused_flags;

    assign data_valid   = ctrl.isstring | ctrl.ispattern;
    // Only the READ and PROC completion flags carry meaning.
    assign unused_flags = ctrl.dp_flags[S_OUT];

    // Saturating increment of the per-string pattern counter.
    always_comb begin
        pat_cnt_d = pat_cnt_q;
        if (pat_cnt_q != 8'hFF) begin
            pat_cnt_d = pat_cnt_q + 8'd1;
        end
    end

    // Phase sequencing, watchdog and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            seen_data_q   <= 1'b0;
            wd_q          <= '0;
            timeout_q     <= 1'b0;
            proc_cycles_q <= '0;
            pat_cnt_q     <= 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    wd_q        <= '0;
                    seen_data_q <= 1'b0;
                    if (ctrl.en) begin
                        state_q <= ST_READ;
                    end
                end
                ST_READ: begin
                    wd_q <= '0;
                    if (ctrl.isstring) begin
                        pat_cnt_q <= 8'd0;
                    end
                    // Leave on the first idle cycle after at least one character.
                    if (seen_data_q && ctrl.dp_flags[S_READ]) begin
                        state_q     <= ST_PROC;
                        seen_data_q <= 1'b0;
                        wd_q        <= CYC_W'(1);
                        timeout_q   <= 1'b0;
                    end else if (data_valid) begin
                        seen_data_q <= 1'b1;
                    end
                end
                ST_PROC: begin
                    // Normal completion takes priority over the watchdog.
                    if (ctrl.dp_flags[S_PROC]) begin
                        state_q       <= ST_OUT;
                        timeout_q     <= 1'b0;
                        proc_cycles_q <= wd_q;
                        wd_q          <= '0;
                    end else if (wd_q == CYC_W'(MAX_PROC)) begin
                        state_q       <= ST_OUT;
                        timeout_q     <= 1'b1;
                        proc_cycles_q <= CYC_W'(MAX_PROC);
                        wd_q          <= '0;
                    end else begin
                        wd_q <= wd_q + CYC_W'(1);
                    end
                end
                ST_OUT: begin
                    wd_q      <= '0;
                    pat_cnt_q <= pat_cnt_d;
                    state_q   <= ctrl.en ? ST_READ : ST_IDLE;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    seen_data_q <= 1'b0;
                    wd_q        <= '0;
                end
            endcase
        end
    end

    assign ctrl.state       = state_q;
    assign ctrl.busy        = (state_q == ST_PROC);
    // Counter is held clear until the first character so it reads 0 on that character.
    assign ctrl.cnt_rst     = (state_q == ST_IDLE) || (state_q == ST_OUT) ||
                              ((state_q == ST_READ) && !seen_data_q && !data_valid);
    assign ctrl.timeout     = timeout_q;
    assign ctrl.proc_cycles = proc_cycles_q;
    assign ctrl.pat_cnt     = pat_cnt_q;
endmodule
